// File: rtl/mem_wb_multi_pkg.sv
// Shared constants, stage-action encoding and helpers for the MEM/WB multi-lane register.
// The optional counters are enabled by defining MEM_WB_PERF_EN.
package mem_wb_multi_pkg;

    localparam int unsigned LANES_DEF   = 2;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned ADDR_W_DEF  = 5;
    localparam int unsigned STALL_W_DEF = 7;

    localparam logic [DATA_W_DEF-1:0] ZERO_WORD     = DATA_W_DEF'(0);
    localparam logic [ADDR_W_DEF-1:0] ZERO_REG_ADDR = ADDR_W_DEF'(0);
    localparam logic                  FALSE_V       = 1'b0;
    localparam logic                  TRUE_V        = 1'b1;

    // What the stage does on a given edge, already prioritised.
    typedef enum logic [1:0] {
        ACT_HOLD    = 2'd0,
        ACT_CAPTURE = 2'd1,
        ACT_BUBBLE  = 2'd2,
        ACT_FLUSH   = 2'd3
    } stage_act_e;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/mem_wb_multi_if.sv
// MEM/WB stage bus: pipeline control, MEM-side lanes, regfile write port, forwarding and counters.
// retired/bubbles carry live values only when MEM_WB_PERF_EN is defined.
interface mem_wb_multi_if
    import mem_wb_multi_pkg::*;
#(
    parameter int unsigned LANES   = LANES_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned STALL_W = STALL_W_DEF,
    parameter int unsigned NFWD    = 2
) ();

    logic [STALL_W-1:0]       stall;
    logic                     flush;
    logic [LANES-1:0]         wreg_i;
    logic [LANES*ADDR_W-1:0]  wd_i;
    logic [LANES*DATA_W-1:0]  wdata_i;
    logic [LANES-1:0]         we;
    logic [LANES*ADDR_W-1:0]  waddr;
    logic [LANES*DATA_W-1:0]  wdata;
    logic [NFWD*ADDR_W-1:0]   fwd_raddr;
    logic [NFWD-1:0]          fwd_hit;
    logic [NFWD*DATA_W-1:0]   fwd_data;
    logic [63:0]              retired;
    logic [31:0]              bubbles;

    modport master (
        output stall, flush, wreg_i, wd_i, wdata_i, fwd_raddr,
        input  we, waddr, wdata, fwd_hit, fwd_data, retired, bubbles
    );

    modport slave (
        input  stall, flush, wreg_i, wd_i, wdata_i, fwd_raddr,
        output we, waddr, wdata, fwd_hit, fwd_data, retired, bubbles
    );

endinterface

// File: rtl/mem_wb_multi_fwd_lookup.sv
// One forwarding lookup port: matches a read address against the live registered write lanes.
module mem_wb_fwd_lookup
    import mem_wb_multi_pkg::*;
#(
    parameter int unsigned LANES  = LANES_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic [LANES-1:0]        we,
    input  logic [LANES*ADDR_W-1:0] waddr,
    input  logic [LANES*DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0]       raddr,
    output logic                    hit_c,
    output logic [DATA_W-1:0]       data_c
);

    // Ascending scan so the highest matching lane provides the data.
    always_comb begin
        hit_c  = FALSE_V;
        data_c = DATA_W'(ZERO_WORD);
        if (raddr != ADDR_W'(ZERO_REG_ADDR)) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                if (we[k] && (waddr[k*ADDR_W +: ADDR_W] == raddr)) begin
                    hit_c  = TRUE_V;
                    data_c = wdata[k*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: rtl/mem_wb_multi.sv
// MEM/WB pipeline register for LANES write-back slots with stall/bubble/flush, x0 and
// same-destination suppression, forwarding lookups; retire/bubble counters under MEM_WB_PERF_EN.
module mem_wb_multi
    import mem_wb_multi_pkg::*;
#(
    parameter int unsigned LANES     = LANES_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned STALL_W   = STALL_W_DEF,
    parameter int unsigned STAGE_IDX = 5,
    parameter int unsigned NFWD      = 2
) (
    input logic            clk,
    input logic            rst,
    mem_wb_multi_if.slave  bus
);

    logic [LANES-1:0]        qual_c;
    logic [LANES-1:0]        keep_c;
    logic [LANES-1:0]        we_q;
    logic [LANES*ADDR_W-1:0] waddr_q;
    logic [LANES*DATA_W-1:0] wdata_q;
    stage_act_e              act_c;
    logic                    unused_stall;

    // Only this stage's bit and the next stage's bit matter.
    assign unused_stall = ^bus.stall;

    always_comb begin
        act_c = ACT_HOLD;
        if (bus.flush) begin
            act_c = ACT_FLUSH;
        end else if (!bus.stall[STAGE_IDX]) begin
            act_c = ACT_CAPTURE;
        end else if (!bus.stall[STAGE_IDX+1]) begin
            act_c = ACT_BUBBLE;
        end
    end

    // A lane is dropped when a later lane in the bundle writes the same register.
    for (genvar k = 0; k < LANES; k++) begin : g_qual
        logic [ADDR_W-1:0] addr_k;
        logic              shadowed_c;

        assign addr_k    = bus.wd_i[k*ADDR_W +: ADDR_W];
        assign qual_c[k] = bus.wreg_i[k] && (addr_k != ADDR_W'(ZERO_REG_ADDR));

        always_comb begin
            shadowed_c = FALSE_V;
            for (int unsigned j = k + 1; j < LANES; j++) begin
                if (qual_c[j] && (bus.wd_i[j*ADDR_W +: ADDR_W] == addr_k)) begin
                    shadowed_c = TRUE_V;
                end
            end
        end

        assign keep_c[k] = qual_c[k] && !shadowed_c;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            we_q    <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            case (act_c)
                ACT_FLUSH, ACT_BUBBLE: begin
                    we_q    <= '0;
                    waddr_q <= '0;
                    wdata_q <= '0;
                end
                ACT_CAPTURE: begin
                    we_q    <= keep_c;
                    waddr_q <= bus.wd_i;
                    wdata_q <= bus.wdata_i;
                end
                default: ;
            endcase
        end
    end

    assign bus.we    = we_q;
    assign bus.waddr = waddr_q;
    assign bus.wdata = wdata_q;

    logic [NFWD-1:0]        fwd_hit_c;
    logic [NFWD*DATA_W-1:0] fwd_data_c;

    for (genvar p = 0; p < NFWD; p++) begin : g_fwd
        mem_wb_fwd_lookup #(
            .LANES  (LANES),
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_lookup (
            .we     (we_q),
            .waddr  (waddr_q),
            .wdata  (wdata_q),
            .raddr  (bus.fwd_raddr[p*ADDR_W +: ADDR_W]),
            .hit_c  (fwd_hit_c[p]),
            .data_c (fwd_data_c[p*DATA_W +: DATA_W])
        );
    end

    assign bus.fwd_hit  = fwd_hit_c;
    assign bus.fwd_data = fwd_data_c;

`ifdef MEM_WB_PERF_EN
    logic [63:0] retired_q;
    logic [31:0] bubbles_q;

    // Counters clear only on reset; flush and hold leave them alone.
    always_ff @(posedge clk) begin
        if (!rst) begin
            retired_q <= '0;
            bubbles_q <= '0;
        end else begin
            case (act_c)
                ACT_CAPTURE: retired_q <= retired_q + 64'(popcount4(4'(keep_c)));
                ACT_BUBBLE:  bubbles_q <= bubbles_q + 32'd1;
                default: ;
            endcase
        end
    end

    assign bus.retired = retired_q;
    assign bus.bubbles = bubbles_q;
`else
    assign bus.retired = '0;
    assign bus.bubbles = '0;
`endif

endmodule

// File: tb/tb_mem_wb_multi.sv
// Randomised bench for mem_wb_multi against a last-writer-wins reference model.
module tb_mem_wb_multi;
    import mem_wb_multi_pkg::*;

    localparam int unsigned LANES     = 2;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned STALL_W   = 7;
    localparam int unsigned STAGE_IDX = 5;
    localparam int unsigned NFWD      = 2;
`ifdef MEM_WB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_wb_multi_if #(
        .LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STALL_W(STALL_W), .NFWD(NFWD)
    ) bus ();

    mem_wb_multi #(
        .LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .STALL_W(STALL_W), .STAGE_IDX(STAGE_IDX), .NFWD(NFWD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    logic [STALL_W-1:0] s_stall;
    logic               s_flush;
    logic [LANES-1:0]   s_wreg;
    logic [ADDR_W-1:0]  s_addr [LANES];
    logic [DATA_W-1:0]  s_data [LANES];
    logic [ADDR_W-1:0]  s_raddr[NFWD];

    logic [LANES-1:0]   m_we;
    logic [ADDR_W-1:0]  m_addr [LANES];
    logic [DATA_W-1:0]  m_data [LANES];
    logic [63:0]        m_ret;
    logic [31:0]        m_bub;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        bus.stall = s_stall;
        bus.flush = s_flush;
        bus.wreg_i = s_wreg;
        for (int k = 0; k < LANES; k++) begin
            bus.wd_i[k*ADDR_W +: ADDR_W]    = s_addr[k];
            bus.wdata_i[k*DATA_W +: DATA_W] = s_data[k];
        end
        for (int p = 0; p < NFWD; p++) bus.fwd_raddr[p*ADDR_W +: ADDR_W] = s_raddr[p];
    endtask

    task automatic check_outputs(input string tag);
        logic [LANES*ADDR_W-1:0] e_addr;
        logic [LANES*DATA_W-1:0] e_data;
        logic [NFWD-1:0]         e_hit;
        logic [NFWD*DATA_W-1:0]  e_fdata;
        for (int k = 0; k < LANES; k++) begin
            e_addr[k*ADDR_W +: ADDR_W] = m_addr[k];
            e_data[k*DATA_W +: DATA_W] = m_data[k];
        end
        // Expected forward: the last live lane written to the requested register.
        for (int p = 0; p < NFWD; p++) begin
            e_hit[p] = 1'b0;
            e_fdata[p*DATA_W +: DATA_W] = '0;
            for (int k = 0; k < LANES; k++) begin
                if (s_raddr[p] != 0 && m_we[k] && m_addr[k] == s_raddr[p]) begin
                    e_hit[p] = 1'b1;
                    e_fdata[p*DATA_W +: DATA_W] = m_data[k];
                end
            end
        end
        chk({tag, ".we"},       128'(bus.we),       128'(m_we));
        chk({tag, ".waddr"},    128'(bus.waddr),    128'(e_addr));
        chk({tag, ".wdata"},    128'(bus.wdata),    128'(e_data));
        chk({tag, ".fwd_hit"},  128'(bus.fwd_hit),  128'(e_hit));
        chk({tag, ".fwd_data"}, 128'(bus.fwd_data), 128'(e_fdata));
        chk({tag, ".retired"},  128'(bus.retired),  128'(m_ret));
        chk({tag, ".bubbles"},  128'(bus.bubbles),  128'(m_bub));
    endtask

    task automatic clear_regs();
        m_we = '0;
        for (int k = 0; k < LANES; k++) begin
            m_addr[k] = '0;
            m_data[k] = '0;
        end
    endtask

    // Apply the current stimulus for one edge, advance the model, then compare.
    task automatic step(input string tag);
        int owner[int];
        drive();
        if (!rst) begin
            clear_regs();
            m_ret = '0;
            m_bub = '0;
        end else if (s_flush) begin
            clear_regs();
        end else if (!s_stall[STAGE_IDX]) begin
            for (int k = 0; k < LANES; k++)
                if (s_wreg[k] && s_addr[k] != 0) owner[int'(s_addr[k])] = k;
            for (int k = 0; k < LANES; k++) begin
                m_we[k] = owner.exists(int'(s_addr[k])) && owner[int'(s_addr[k])] == k;
                m_addr[k] = s_addr[k];
                m_data[k] = s_data[k];
            end
            if (PERF) m_ret = m_ret + 64'($countones(m_we));
        end else if (!s_stall[STAGE_IDX+1]) begin
            clear_regs();
            if (PERF) m_bub = m_bub + 32'd1;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic set_lane(input int k, input logic w, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
        s_wreg[k] = w;
        s_addr[k] = a;
        s_data[k] = d;
    endtask

    initial begin
        s_stall = '0;
        s_flush = 1'b0;
        for (int p = 0; p < NFWD; p++) s_raddr[p] = '0;
        clear_regs();
        m_ret = '0;
        m_bub = '0;

        rst = 1'b0;
        set_lane(0, 1'b1, 5'd9, 32'hdeadbeef);
        set_lane(1, 1'b1, 5'd10, 32'hcafef00d);
        step("reset0");
        step("reset1");
        rst = 1'b1;

        set_lane(0, 1'b1, 5'd3, 32'h11);
        set_lane(1, 1'b1, 5'd4, 32'h22);
        s_raddr[0] = 5'd0;
        s_raddr[1] = 5'd4;
        step("capture_fwd");

        set_lane(0, 1'b1, 5'd7, 32'hA);
        set_lane(1, 1'b1, 5'd7, 32'hB);
        s_raddr[0] = 5'd7;
        step("same_dest");

        set_lane(0, 1'b1, 5'd0, 32'h5);
        set_lane(1, 1'b0, 5'd9, 32'h6);
        s_raddr[0] = 5'd0;
        step("x0");

        set_lane(0, 1'b1, 5'd12, 32'h1234);
        set_lane(1, 1'b1, 5'd13, 32'h5678);
        step("recapture");
        s_stall = 7'b0100000;
        step("bubble");

        set_lane(0, 1'b1, 5'd14, 32'h99);
        s_stall = 7'b0000000;
        step("pre_hold");
        s_stall = 7'b1100000;
        for (int i = 0; i < 3; i++) step("hold");

        s_flush = 1'b1;
        step("flush_hold");
        s_flush = 1'b0;
        s_stall = '0;

        for (int i = 0; i < 400; i++) begin
            rst     = ($urandom_range(0, 49) != 0);
            s_flush = ($urandom_range(0, 15) == 0);
            s_stall = STALL_W'($urandom);
            for (int k = 0; k < LANES; k++)
                set_lane(k, 1'($urandom), ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom));
            for (int p = 0; p < NFWD; p++) s_raddr[p] = ADDR_W'($urandom_range(0, 7));
            step("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_wb_multi.md
Name: mem_wb_multi

Overview:
Parametrised MEM/WB pipeline register for a multi-issue core: carries LANES write-back slots (enable, register address, data) from MEM to the register file. Adds per-stage stall/bubble control from the shared stall bus, explicit flush, x0 write suppression, and intra-bundle same-destination resolution. Provides registered-stage forwarding lookups for earlier stages, and optional retire/bubble performance counters.

Parameters:
LANES, 2, number of write-back slots per cycle (1..4)
DATA_W, 32, register data width
ADDR_W, 5, register address width
STALL_W, 7, stall bus width
STAGE_IDX, 5, index of this stage in stall bus; STAGE_IDX+1 < STALL_W
NFWD, 2, number of forwarding lookup ports

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
stall  in  STALL_W  pipeline stall bus
flush  in  1  kill content of this stage
wreg_i  in  LANES  per-lane write enable from MEM
wd_i  in  LANES*ADDR_W  per-lane destination, lane k at [k*ADDR_W +: ADDR_W]
wdata_i  in  LANES*DATA_W  per-lane result data
we  out  LANES  registered per-lane write enable to regfile
waddr  out  LANES*ADDR_W  registered destinations
wdata  out  LANES*DATA_W  registered data
fwd_raddr  in  NFWD*ADDR_W  lookup addresses
fwd_hit  out  NFWD  lookup matched a live write in this stage
fwd_data  out  NFWD*DATA_W  matched data (0 when no hit)
retired  out  64  lanes written since reset (PERF only, else 0)
bubbles  out  32  bubble cycles inserted (PERF only, else 0)

Behaviour:
- Latency: one cycle input to outputs; all outputs except fwd_* are registered.
- Priority per rising edge: rst==0 > flush > bubble > capture > hold.
- rst==0: we=0, waddr=0, wdata=0; counters=0.
- flush==1: same clear as reset; counters kept. Overrides any stall value.
- bubble: stall[STAGE_IDX]==1 and stall[STAGE_IDX+1]==0; clear we/waddr/wdata to 0.
- capture: stall[STAGE_IDX]==0; load lanes with qualification below.
- hold: stall[STAGE_IDX]==1 and stall[STAGE_IDX+1]==1; all registers unchanged.
- Qualification on capture, lane k:
  - we[k] = wreg_i[k] && wd_i[k]!=0. x0 never written. waddr/wdata still captured.
  - Same destination: if lane j>k also qualifies with the same address, we[k]=0. The highest lane wins, so program order is lane ascending.
- Forwarding, combinational from registered outputs:
  - fwd_hit[p]=1 iff some lane has we=1 and waddr==fwd_raddr[p], with fwd_raddr[p]!=0.
  - fwd_data = data of highest matching lane.
  - By construction at most one lane matches.
- Reset and flush take effect regardless of stall. Stall bits outside STAGE_IDX and STAGE_IDX+1 are ignored.
- Width rules: buses packed lane 0 at LSBs. Counters wrap modulo 2^64 and 2^32 with no saturation.

Optional Feature:
MEM_WB_PERF_EN
- Defined:
  - On capture, retired += popcount of qualified we being loaded.
  - On each bubble edge, bubbles += 1.
  - Counters hold on flush, hold, and stall; they clear only on rst==0.
- Undefined: no counter flops; retired and bubbles are tied to 0.

Decomposition:
- Shared defines file: StallBus width, ZeroWord, ZeroRegAddr, False_v/True_v, and default LANES/DATA_W/ADDR_W constants.
- One natural sub-module, mem_wb_fwd_lookup: combinational match for one lookup port, instantiated NFWD times.
- Lane qualification stays inline in a generate loop.

Test Plan:
- Reset: rst=0 for 2 cycles with wreg_i=2'b11 and arbitrary data -> we=0, waddr=0, wdata=0; retired=0.
- Capture: stall=0, lane0 (1, x3, 0x11), lane1 (1, x4, 0x22) -> next cycle we=2'b11, waddr={4,3}, wdata={0x22,0x11}; retired=2 with PERF.
- Same destination and x0: lane0 (1, x7, 0xA), lane1 (1, x7, 0xB) -> we=2'b10. Next cycle lane0 (1, x0, 0x5) -> we[0]=0.
- Bubble versus hold:
  - stall=7'b0100000 -> outputs cleared; bubbles increments.
  - Then stall=7'b1100000 -> outputs held for 3 cycles; bubbles unchanged.
- Flush during hold: stall=7'b1100000, flush=1 -> we=0 next cycle despite hold.
- Forwarding: registered lane1 writes x4=0x22; fwd_raddr={x4, x0} -> fwd_hit=2'b10 (port1 = x4), fwd_data port1=0x22, port0=0.
